seq_booth_multiplier: RTL

Parametrised sequential multiplier that computes one radix-2 Booth step per clock. It supports signed and unsigned operands, selectable per operation, and uses a start/busy/done handshake. It is the multi-width successor to the team's fixed 4-bit shift-add multiplier and serves as the shared multiply unit for datapath blocks that can tolerate WIDTH+1 cycles of latency.

---
 rtl/seq_booth_multiplier.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier that retires one step per clock, for signed or unsigned operands.
// The operands are extended to WIDTH+1 bits, so WIDTH+1 steps are needed: one on the capture edge and WIDTH while running.
module seq_booth_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // The accumulator has one guard bit beyond the operand width, so add/subtract can never overflow it.
  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       acc_a_q, acc_a_d;
  logic [QW-1:0]       acc_q_q, acc_q_d;
  logic                q1_q, q1_d;
  logic [AW-1:0]       m_q, m_d;
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                capture;
  logic [AW-1:0]       ext_a;
  logic [QW-1:0]       ext_b;
  logic [AW-1:0]       src_a, src_m, sum;
  logic [QW-1:0]       src_q;
  logic                src_q1;
  logic [AW-1:0]       step_a;
  logic [QW-1:0]       step_q;
  logic                step_q1;
  logic [2*WIDTH-1:0]  prod;

  assign capture = start && ((state_q == IDLE) || (state_q == DONE));
  assign ext_a   = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
  assign ext_b   = signed_mode ? {b[WIDTH-1], b} : {1'b0, b};

  // The capture edge performs the first step directly on the freshly loaded operands.
  always_comb begin
    src_a  = capture ? '0    : acc_a_q;
    src_q  = capture ? ext_b : acc_q_q;
    src_q1 = capture ? 1'b0  : q1_q;
    src_m  = capture ? ext_a : m_q;
    case ({src_q[0], src_q1})
      2'b01:   sum = src_a + src_m;
      2'b10:   sum = src_a - src_m;
      default: sum = src_a;
    endcase
    step_a  = {sum[AW-1], sum[AW-1:1]};
    step_q  = {sum[0], src_q[QW-1:1]};
    step_q1 = src_q[0];
    prod    = {step_a[WIDTH-2:0], step_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_a_d = acc_a_q;
    acc_q_d = acc_q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    p_d     = p_q;
    case (state_q)
      IDLE, DONE: begin
        if (capture) begin
          state_d = RUN;
          cnt_d   = '0;
          m_d     = ext_a;
          acc_a_d = step_a;
          acc_q_d = step_q;
          q1_d    = step_q1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_a_d = step_a;
        acc_q_d = step_q;
        q1_d    = step_q1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          p_d     = prod;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_a_q <= '0;
      acc_q_q <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_a_q <= acc_a_d;
      acc_q_q <= acc_q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = p_q;

endmodule
